// File: rtl/serial_arb_pkg.sv
// Shared types and defaults for the serial burst arbiter: FSM encoding,
// default sizing and the grant-index width helper.
package serial_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_READ = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_GAP_CYCLES = 8;
    localparam int DEF_MAX_BITS   = 1024;
    localparam int DEF_CNT_W      = 11;

    // Width needed to index 'value' items; never less than 1.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((32'd1 << w) < 32'(value)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_burst_arbiter_rr_picker.sv
// Combinational round-robin select: first requesting lane after rr_last,
// wrapping around; rr_last itself is considered last.
module rr_picker
    import serial_arb_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int GW     = clog2(DEF_NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [GW-1:0]     rr_last,
    output logic [GW-1:0]     pick,
    output logic              found
);

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            automatic logic [GW-1:0] idx = GW'((int'(rr_last) + i) % NUM_CH);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/serial_burst_arbiter.sv
// Round-robin scheduler sharing one serial output between NUM_CH lane FIFOs.
// Per grant: IDLE -> ARB -> READ (until almost-empty or bit cap) -> GAP.
module serial_burst_arbiter
    import serial_arb_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int MAX_BITS   = DEF_MAX_BITS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk20m,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic [NUM_CH-1:0] i_burst_req,
    input  logic [NUM_CH-1:0] i_fifo_aempty,
    input  logic [NUM_CH-1:0] i_fifo_dout,
    output logic [NUM_CH-1:0] o_fifo_rd_en,
    output logic              o_data,
    output logic              o_data_valid,
    output logic [2:0]        o_grant_id,
    output logic              o_busy,
    output logic              o_cap_hit,
    output logic              o_empty_grant
);

    localparam int              GW       = clog2(NUM_CH);
    localparam logic [CNT_W-1:0] CAP     = CNT_W'(MAX_BITS);
    localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [GW-1:0]    grant;
    logic [GW-1:0]    rr_last;
    logic [GW-1:0]    grant_d1;
    logic [GW-1:0]    pick;
    logic             found;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       gap_cnt;
    logic             lane_aempty;
    logic             below_cap;
    logic             rd_go;
    logic             rd_d1;
    logic             take_grant;

    rr_picker #(
        .NUM_CH (NUM_CH),
        .GW     (GW)
    ) u_picker (
        .req     (i_burst_req),
        .rr_last (rr_last),
        .pick    (pick),
        .found   (found)
    );

    assign lane_aempty = i_fifo_aempty[grant];
    assign below_cap   = (bit_cnt < CAP);
    // Read strobe is gated by the live almost-empty flag so we never overshoot.
    assign rd_go       = (state == ST_READ) && !lane_aempty && below_cap;
    assign take_grant  = (state == ST_IDLE) && i_enable && found;
    assign o_busy      = (state != ST_IDLE);

    always_comb begin
        o_fifo_rd_en = '0;
        if (rd_go) begin
            o_fifo_rd_en[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk20m or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (take_grant) state_nxt = ST_ARB;
            ST_ARB:  state_nxt = lane_aempty ? ST_GAP : ST_READ;
            ST_READ: if (!rd_go) state_nxt = ST_GAP;
            ST_GAP:  if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk20m or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= '0;
            rr_last    <= GW'(NUM_CH - 1);
            o_grant_id <= '0;
        end else if (take_grant) begin
            grant      <= pick;
            rr_last    <= pick;
            o_grant_id <= 3'(pick);
        end
    end

    always_ff @(posedge clk20m or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (state == ST_ARB) begin
                bit_cnt <= '0;
            end else if (rd_go) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == ST_GAP) begin
                gap_cnt <= (gap_cnt == GAP_LAST) ? 8'd0 : gap_cnt + 8'd1;
            end
        end
    end

    // Cap takes precedence over almost-empty when both end the same grant.
    always_ff @(posedge clk20m or negedge rst_n) begin
        if (!rst_n) begin
            o_empty_grant <= 1'b0;
            o_cap_hit     <= 1'b0;
        end else begin
            o_empty_grant <= (state == ST_ARB) && lane_aempty;
            o_cap_hit     <= (state == ST_READ) && !below_cap;
        end
    end

    // grant_d1 lets the final bits of a grant drain while the FSM sits in GAP.
    always_ff @(posedge clk20m or negedge rst_n) begin
        if (!rst_n) begin
            rd_d1        <= 1'b0;
            grant_d1     <= '0;
            o_data       <= 1'b0;
            o_data_valid <= 1'b0;
        end else begin
            rd_d1        <= rd_go;
            grant_d1     <= grant;
            o_data_valid <= rd_d1;
            o_data       <= rd_d1 ? i_fifo_dout[grant_d1] : 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_burst_arbiter.sv
// Directed bench for serial_burst_arbiter with behavioural lane FIFOs.
module tb_serial_burst_arbiter;

    localparam int NUM_CH = 4;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] fifo_aempty;
    logic [NUM_CH-1:0] fifo_dout;
    logic [NUM_CH-1:0] fifo_rd_en;
    logic              data;
    logic              data_valid;
    logic [2:0]        grant_id;
    logic              busy;
    logic              cap_hit;
    logic              empty_grant;

    int checks = 0;
    int errors = 0;

    logic         load_en = 1'b0;
    int           load_ch = 0;
    int           load_n  = 0;
    logic [127:0] load_pat = '0;

    int           rd_cnt [NUM_CH];
    int           grant_ids [16];
    int           grant_cyc [16];
    int           n_grants;
    int           valid_cnt;
    int           busy_cnt;
    int           cap_cnt;
    int           eg_cnt;
    int           multi_rd;
    int           first_rd;
    int           first_valid;
    logic [127:0] cap_vec;

    serial_burst_arbiter #(
        .NUM_CH     (NUM_CH),
        .GAP_CYCLES (8),
        .MAX_BITS   (32),
        .CNT_W      (11)
    ) dut (
        .clk20m        (clk),
        .rst_n         (rst_n),
        .i_enable      (enable),
        .i_burst_req   (req),
        .i_fifo_aempty (fifo_aempty),
        .i_fifo_dout   (fifo_dout),
        .o_fifo_rd_en  (fifo_rd_en),
        .o_data        (data),
        .o_data_valid  (data_valid),
        .o_grant_id    (grant_id),
        .o_busy        (busy),
        .o_cap_hit     (cap_hit),
        .o_empty_grant (empty_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane FIFO: bits leave LSB first, dout one clock after rd_en, aempty when drained.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        logic [127:0] pat;
        logic [6:0]   ptr;
        logic         dout;
        int           cnt;
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pat  <= '0;
                ptr  <= '0;
                dout <= 1'b0;
                cnt  <= 0;
            end else if (load_en && load_ch == g) begin
                pat <= load_pat;
                ptr <= '0;
                cnt <= load_n;
            end else if (fifo_rd_en[g]) begin
                dout <= pat[ptr];
                ptr  <= ptr + 7'd1;
                cnt  <= cnt - 1;
            end
        end
        assign fifo_dout[g]   = dout;
        assign fifo_aempty[g] = (cnt == 0);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        req    = '0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load(input int ch, input int n, input logic [127:0] p);
        load_ch  = ch;
        load_n   = n;
        load_pat = p;
        load_en  = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Samples ncyc negedges, recording grants, reads and output bits.
    task automatic observe(input int ncyc, input int req_off_at, input int en_off_at);
        logic prev_busy;
        prev_busy = busy;
        for (int ch = 0; ch < NUM_CH; ch++) rd_cnt[ch] = 0;
        n_grants = 0; valid_cnt = 0; busy_cnt = 0; cap_cnt = 0; eg_cnt = 0;
        multi_rd = 0; first_rd = -1; first_valid = -1; cap_vec = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (busy && !prev_busy && n_grants < 16) begin
                grant_ids[n_grants] = int'(grant_id);
                grant_cyc[n_grants] = c;
                n_grants++;
            end
            prev_busy = busy;
            if (busy) busy_cnt++;
            for (int ch = 0; ch < NUM_CH; ch++) if (fifo_rd_en[2'(ch)]) rd_cnt[ch]++;
            if (fifo_rd_en != '0 && first_rd < 0) first_rd = c;
            if ($countones(fifo_rd_en) > 1) multi_rd++;
            if (data_valid) begin
                if (first_valid < 0) first_valid = c;
                if (valid_cnt < 128) cap_vec[7'(valid_cnt)] = data;
                valid_cnt++;
            end
            if (cap_hit) cap_cnt++;
            if (empty_grant) eg_cnt++;
            if (c == req_off_at) req = '0;
            if (c == en_off_at) enable = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({fifo_rd_en, data, data_valid, busy} !== '0) begin
            errors++;
            $display("FAIL reset_datapath: got %b required 0", {fifo_rd_en, data, data_valid, busy});
        end
        checks++;
        if (grant_id !== 3'd0) begin
            errors++;
            $display("FAIL reset_grant_id: got %0d required 0", grant_id);
        end
        checks++;
        if ({cap_hit, empty_grant} !== 2'b00) begin
            errors++;
            $display("FAIL reset_pulses: got %b required 00", {cap_hit, empty_grant});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: busy=%b required 0", busy);
        end
    endtask

    task automatic test_single_lane();
        load(1, 16, 128'hA5C3);
        req = 4'b0010;
        observe(40, 0, -1);
        checks++;
        if (rd_cnt[1] != 16 || rd_cnt[0] != 0 || rd_cnt[2] != 0 || rd_cnt[3] != 0) begin
            errors++;
            $display("FAIL single_reads: got %0d/%0d/%0d/%0d required 0/16/0/0", rd_cnt[0], rd_cnt[1], rd_cnt[2], rd_cnt[3]);
        end
        checks++;
        if (valid_cnt != 16) begin
            errors++;
            $display("FAIL single_valid_cnt: got %0d required 16", valid_cnt);
        end
        checks++;
        if (first_rd != 1 || first_valid != 3) begin
            errors++;
            $display("FAIL single_latency: first rd %0d valid %0d, required 1 and 3", first_rd, first_valid);
        end
        checks++;
        if (cap_vec[15:0] !== 16'hA5C3) begin
            errors++;
            $display("FAIL single_bits: got %h required a5c3", cap_vec[15:0]);
        end
        checks++;
        if (busy_cnt != 26) begin
            errors++;
            $display("FAIL single_busy_len: got %0d required 26", busy_cnt);
        end
        checks++;
        if (n_grants != 1 || grant_ids[0] != 1) begin
            errors++;
            $display("FAIL single_grant: got %0d grants first %0d, required 1 grant of ch1", n_grants, grant_ids[0]);
        end
        wait_idle();
    endtask

    task automatic test_round_robin();
        do_reset();
        load(0, 8, 128'h3C);
        load(1, 8, 128'hA7);
        load(2, 8, 128'h51);
        load(3, 8, 128'hE8);
        req = 4'b1111;
        observe(80, 79, -1);
        checks++;
        if (n_grants != 5 || grant_ids[0] != 0 || grant_ids[1] != 1 || grant_ids[2] != 2
            || grant_ids[3] != 3 || grant_ids[4] != 0) begin
            errors++;
            $display("FAIL rr_order: %0d grants %0d,%0d,%0d,%0d,%0d required 0,1,2,3,0",
                     n_grants, grant_ids[0], grant_ids[1], grant_ids[2], grant_ids[3], grant_ids[4]);
        end
        checks++;
        if (grant_cyc[1] != 19 || grant_cyc[4] != 76) begin
            errors++;
            $display("FAIL rr_spacing: grant1 at %0d grant4 at %0d, required 19 and 76", grant_cyc[1], grant_cyc[4]);
        end
        checks++;
        if (valid_cnt != 32 || cap_vec[31:0] !== 32'hE851A73C) begin
            errors++;
            $display("FAIL rr_bits: %0d bits %h required 32 bits e851a73c", valid_cnt, cap_vec[31:0]);
        end
        checks++;
        if (eg_cnt != 1 || multi_rd != 0) begin
            errors++;
            $display("FAIL rr_empty_onehot: empty pulses %0d multi-rd %0d, required 1 and 0", eg_cnt, multi_rd);
        end
        wait_idle();
    endtask

    task automatic test_cap();
        do_reset();
        load(0, 4, 128'h9);
        load(2, 100, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        load(3, 4, 128'h6);
        req = 4'b1101;
        observe(84, 83, -1);
        checks++;
        if (n_grants != 5 || grant_ids[0] != 0 || grant_ids[1] != 2 || grant_ids[2] != 3
            || grant_ids[3] != 0 || grant_ids[4] != 2) begin
            errors++;
            $display("FAIL cap_order: %0d grants %0d,%0d,%0d,%0d,%0d required 0,2,3,0,2",
                     n_grants, grant_ids[0], grant_ids[1], grant_ids[2], grant_ids[3], grant_ids[4]);
        end
        checks++;
        if (rd_cnt[2] != 32 || rd_cnt[0] != 4 || rd_cnt[3] != 4) begin
            errors++;
            $display("FAIL cap_reads: ch0 %0d ch2 %0d ch3 %0d required 4, 32, 4", rd_cnt[0], rd_cnt[2], rd_cnt[3]);
        end
        checks++;
        if (cap_cnt != 1) begin
            errors++;
            $display("FAIL cap_pulse: got %0d pulses required 1", cap_cnt);
        end
        wait_idle();
    endtask

    task automatic test_empty_grant();
        do_reset();
        load(1, 8, 128'h5A);
        req = 4'b0011;
        observe(30, 10, -1);
        checks++;
        if (n_grants != 2 || grant_ids[0] != 0 || grant_ids[1] != 1 || grant_cyc[1] != 10) begin
            errors++;
            $display("FAIL empty_seq: %0d grants ids %0d,%0d second at %0d, required ch0 then ch1 at 10",
                     n_grants, grant_ids[0], grant_ids[1], grant_cyc[1]);
        end
        checks++;
        if (eg_cnt != 1 || rd_cnt[0] != 0 || rd_cnt[1] != 8) begin
            errors++;
            $display("FAIL empty_pulse: pulses %0d ch0 reads %0d ch1 reads %0d, required 1, 0, 8", eg_cnt, rd_cnt[0], rd_cnt[1]);
        end
        wait_idle();
    endtask

    task automatic test_enable_low();
        do_reset();
        load(1, 16, 128'hBEEF);
        req = 4'b0010;
        observe(50, -1, 5);
        checks++;
        if (rd_cnt[1] != 16 || cap_vec[15:0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL en_low_reads: %0d reads bits %h, required 16 and beef", rd_cnt[1], cap_vec[15:0]);
        end
        checks++;
        if (n_grants != 1 || busy_cnt != 26 || busy !== 1'b0) begin
            errors++;
            $display("FAIL en_low_hold: grants %0d busy cycles %0d busy %b, required 1, 26, 0", n_grants, busy_cnt, busy);
        end
        req    = '0;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        load(0, 16, 128'hFFFF);
        req = 4'b0001;
        repeat (8) @(negedge clk);
        checks++;
        if (fifo_rd_en !== 4'b0001 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: rd_en %b valid %b, required 0001 and 1", fifo_rd_en, data_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_rd_en !== 4'b0000 || data_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: rd_en %b valid %b busy %b, required all 0", fifo_rd_en, data_valid, busy);
        end
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load(0, 8, 128'h11);
        load(1, 8, 128'h22);
        req = 4'b0011;
        observe(5, 0, -1);
        checks++;
        if (n_grants != 1 || grant_ids[0] != 0) begin
            errors++;
            $display("FAIL rst_first_grant: %0d grants id %0d, required ch0", n_grants, grant_ids[0]);
        end
        wait_idle();
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        req    = '0;
        test_reset();
        test_single_lane();
        test_round_robin();
        test_cap();
        test_empty_grant();
        test_enable_low();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
